xor_descrambler: RTL and testbench



---
 rtl/xor_descrambler.sv | 103 ++++++++++
 tb/tb_xor_descrambler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/xor_descrambler.sv
// Receive-side XOR descrambler: masks each accepted beat with N keystream bits from a 16-bit Fibonacci LFSR.
// Optional XOR_DESCR_CNT_EN adds a beat_cnt output counting accepts since the last seed_load or reset.
module xor_descrambler #(
   parameter int unsigned N        = 4,
   parameter logic [15:0] DEF_SEED = 16'hACE1
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         seed_load,
   input  logic [15:0]  seed,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
`ifdef XOR_DESCR_CNT_EN
   output logic [15:0]  beat_cnt,
`endif
   output logic         locked
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [15:0] lfsr;
   logic [15:0] lfsr_adv;
   logic [15:0] seed_val;
   logic [N-1:0] key;
   logic        accept;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (seed_load) state_next = RUN;
         RUN:     state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   assign locked   = (state == RUN);
   // seed_load wins over a same-cycle beat so no data is masked with the stale keystream
   assign in_ready = locked && (!out_valid || out_ready) && !seed_load;
   assign accept   = in_valid && in_ready;
   assign seed_val = (seed == '0) ? DEF_SEED : seed;

   // Keystream bit i is the feedback produced on step i of this beat
   always_comb begin : keystream
      logic fb;
      lfsr_adv = lfsr;
      key      = '0;
      fb       = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         fb       = lfsr_adv[15] ^ lfsr_adv[13] ^ lfsr_adv[12] ^ lfsr_adv[10];
         key[i]   = fb;
         lfsr_adv = {lfsr_adv[14:0], fb};
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         lfsr      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (seed_load) begin
            lfsr <= seed_val;
         end else if (accept) begin
            lfsr <= lfsr_adv;
         end

         if (accept) begin
            out_data  <= in_data ^ key;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef XOR_DESCR_CNT_EN
   always_ff @(posedge clk) begin
      if (!rstn || seed_load) begin
         beat_cnt <= '0;
      end else if (accept) begin
         beat_cnt <= beat_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_xor_descrambler.sv
// Directed bench for xor_descrambler (N=4); expected keystream values are worked out by hand from the LFSR taps.
module tb_xor_descrambler;

   logic        clk;
   logic        rstn;
   logic        seed_load;
   logic [15:0] seed;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_data;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_data;
   logic        locked;
`ifdef XOR_DESCR_CNT_EN
   logic [15:0] beat_cnt;
`endif

   int unsigned chk_cnt;
   int unsigned pass_cnt;

   xor_descrambler #(.N(4), .DEF_SEED(16'hACE1)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .seed_load (seed_load),
      .seed      (seed),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
`ifdef XOR_DESCR_CNT_EN
      .beat_cnt  (beat_cnt),
`endif
      .locked    (locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
      chk_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] burst_exp [4];

   initial begin
      chk_cnt   = 0;
      pass_cnt  = 0;
      rstn      = 1'b0;
      seed_load = 1'b0;
      seed      = 16'h0000;
      in_valid  = 1'b0;
      in_data   = 4'h0;
      out_ready = 1'b0;
      burst_exp[0] = 4'h5;
      burst_exp[1] = 4'h5;
      burst_exp[2] = 4'h1;
      burst_exp[3] = 4'hE;

      // Reset then idle
      tick();
      tick();
      check("rst_out_valid", {15'd0, out_valid}, 16'd0);
      check("rst_locked", {15'd0, locked}, 16'd0);
      check("rst_out_data", {12'd0, out_data}, 16'd0);
      check("rst_lfsr", dut.lfsr, 16'h0000);
      rstn     = 1'b1;
      in_valid = 1'b1;
      in_data  = 4'h6;
      #1;
      check("idle_in_ready", {15'd0, in_ready}, 16'd0);
      tick();
      check("idle_no_accept", {15'd0, out_valid}, 16'd0);
      check("idle_locked", {15'd0, locked}, 16'd0);

      // Seed 8000, beat A -> B
      in_valid  = 1'b0;
      seed_load = 1'b1;
      seed      = 16'h8000;
      tick();
      seed_load = 1'b0;
      check("seed_locked", {15'd0, locked}, 16'd1);
      check("seed_lfsr", dut.lfsr, 16'h8000);
      in_valid = 1'b1;
      in_data  = 4'hA;
      #1;
      check("run_in_ready", {15'd0, in_ready}, 16'd1);
      tick();
      in_valid = 1'b0;
      check("b1_valid", {15'd0, out_valid}, 16'd1);
      check("b1_data", {12'd0, out_data}, 16'h000B);
      check("b1_lfsr", dut.lfsr, 16'h0008);

      // Backpressure with a second beat offered
      in_valid = 1'b1;
      in_data  = 4'h3;
      #1;
      check("bp_in_ready", {15'd0, in_ready}, 16'd0);
      tick();
      check("bp_valid", {15'd0, out_valid}, 16'd1);
      check("bp_data", {12'd0, out_data}, 16'h000B);
      check("bp_lfsr", dut.lfsr, 16'h0008);
      out_ready = 1'b1;
      #1;
      check("drain_in_ready", {15'd0, in_ready}, 16'd1);
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("b2_valid", {15'd0, out_valid}, 16'd1);
      check("b2_data", {12'd0, out_data}, 16'h0003);
      check("b2_lfsr", dut.lfsr, 16'h0080);
`ifdef XOR_DESCR_CNT_EN
      check("cnt_two", beat_cnt, 16'd2);
`endif

      // seed_load with zero seed blocks a same-cycle beat; held beat still drains
      seed_load = 1'b1;
      seed      = 16'h0000;
      in_valid  = 1'b1;
      in_data   = 4'hF;
      out_ready = 1'b1;
      #1;
      check("sl_in_ready", {15'd0, in_ready}, 16'd0);
      check("sl_held_data", {12'd0, out_data}, 16'h0003);
      tick();
      seed_load = 1'b0;
      check("sl_lfsr", dut.lfsr, 16'hACE1);
      check("sl_no_accept", {15'd0, out_valid}, 16'd0);
`ifdef XOR_DESCR_CNT_EN
      check("cnt_clear", beat_cnt, 16'd0);
`endif
      in_data = 4'h0;
      tick();
      in_valid = 1'b0;
      check("def_valid", {15'd0, out_valid}, 16'd1);
      check("def_data", {12'd0, out_data}, 16'h0007);
      check("def_lfsr", dut.lfsr, 16'hCE1E);

      // Seed 0001, four back-to-back beats of 5
      seed_load = 1'b1;
      seed      = 16'h0001;
      tick();
      seed_load = 1'b0;
      in_valid  = 1'b1;
      in_data   = 4'h5;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("burst_ready%0d", i), {15'd0, in_ready}, 16'd1);
         tick();
         check($sformatf("burst_valid%0d", i), {15'd0, out_valid}, 16'd1);
         check($sformatf("burst_data%0d", i), {12'd0, out_data}, {12'd0, burst_exp[i]});
      end
      check("burst_lfsr", dut.lfsr, 16'h002D);
`ifdef XOR_DESCR_CNT_EN
      check("cnt_burst", beat_cnt, 16'd4);
`endif

      // Mid-stream reset with a held beat
      in_data   = 4'h9;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      check("mr_held", {15'd0, out_valid}, 16'd1);
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      check("mr_valid", {15'd0, out_valid}, 16'd0);
      check("mr_locked", {15'd0, locked}, 16'd0);
      check("mr_in_ready", {15'd0, in_ready}, 16'd0);
      check("mr_data", {12'd0, out_data}, 16'd0);
      in_valid = 1'b1;
      tick();
      check("mr_idle_valid", {15'd0, out_valid}, 16'd0);
      in_valid  = 1'b0;
      seed_load = 1'b1;
      seed      = 16'h8000;
      tick();
      seed_load = 1'b0;
      in_valid  = 1'b1;
      in_data   = 4'hA;
      #1;
      check("resume_ready", {15'd0, in_ready}, 16'd1);
      tick();
      in_valid = 1'b0;
      check("resume_data", {12'd0, out_data}, 16'h000B);
      check("resume_valid", {15'd0, out_valid}, 16'd1);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
